// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two write ports,
// optional write-to-read forwarding and a one-register-per-cycle clear sweep.
//
// state | meaning
// IDLE  | normal operation, writes land in the array, busy=0
// CLEAR | sweep zeroes register cnt each edge, writes dropped, busy=1
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int NREAD  = 4,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  output logic                   busy,
  input  logic [NREAD*AW-1:0]    rd_addr,
  input  logic [NREAD-1:0]       rd_zero,
  input  logic                   const_sel,
  input  logic [WIDTH-1:0]       constant,
  output logic [NREAD*WIDTH-1:0] rd_data,
  input  logic [1:0]             wr_en,
  input  logic [AW-1:0]          wr_addr0,
  input  logic [AW-1:0]          wr_addr1,
  input  logic [WIDTH-1:0]       wr_data0,
  input  logic [WIDTH-1:0]       wr_data1,
  output logic                   wr_conflict,
  output logic                   wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0] mem [DEPTH];

  assign busy = (state == CLEAR);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) state_n = IDLE;
      end
      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      cnt         <= '0;
      wr_conflict <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wr_conflict <= (state == IDLE) && (&wr_en) && (wr_addr0 == wr_addr1);
      wr_drop     <= (state == CLEAR) && (|wr_en);
    end
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (wr_en[0]) mem[wr_addr0] <= wr_data0;
        if (wr_en[1]) mem[wr_addr1] <= wr_data1;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] val;

    assign addr = rd_addr[i*AW +: AW];

    // Lowest-priority source first; each later override has higher priority.
    always_comb begin
      val = mem[addr];
      if (BYPASS != 0) begin
        if (wr_en[1] && (wr_addr1 == addr))      val = wr_data1;
        else if (wr_en[0] && (wr_addr0 == addr)) val = wr_data0;
      end
      if ((i == 0) && const_sel) val = constant;
      if (rd_zero[i])            val = '0;
      if (busy)                  val = '0;
    end

    assign rd_data[i*WIDTH +: WIDTH] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a behavioural array model checked every
// cycle, plus literal expectations for reset, bypass, conflict and clear.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        busy;
  logic [15:0] rd_addr;
  logic [3:0]  rd_zero;
  logic        const_sel;
  logic [31:0] constant;
  logic [127:0] rd_data;
  logic [1:0]  wr_en;
  logic [3:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        wr_conflict, wr_drop;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .rd_addr(rd_addr), .rd_zero(rd_zero), .const_sel(const_sel),
    .constant(constant), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_conflict(wr_conflict), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sweep tracked as "registers still to clear", array as a plain array.
  logic [31:0] m_mem [16];
  int          m_left = 16;
  bit          m_valid = 0;
  bit          m_conf = 0, m_drop = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_left  = 16;
      m_conf  = 0;
      m_drop  = 0;
    end else if (m_left > 0) begin
      m_mem[16 - m_left] = 32'h0;
      m_left--;
      m_drop = (wr_en != 2'b00);
      m_conf = 0;
    end else begin
      m_drop = 0;
      m_conf = (wr_en == 2'b11) && (wr_addr0 == wr_addr1);
      if (wr_en[0]) m_mem[wr_addr0] = wr_data0;
      if (wr_en[1]) m_mem[wr_addr1] = wr_data1;
      if (clear) m_left = 16;
    end
  end

  function automatic logic [31:0] exp_rd(input int i);
    logic [3:0] a;
    a = rd_addr[i*4 +: 4];
    if (m_left > 0)                   return 32'h0;
    if (rd_zero[i])                   return 32'h0;
    if (i == 0 && const_sel)          return constant;
    if (wr_en[1] && wr_addr1 == a)    return wr_data1;
    if (wr_en[0] && wr_addr0 == a)    return wr_data0;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_left > 0});
      chk("model_conflict", {31'b0, wr_conflict}, {31'b0, m_conf});
      chk("model_drop", {31'b0, wr_drop}, {31'b0, m_drop});
      for (int p = 0; p < 4; p++)
        chk($sformatf("model_rd%0d", p), rd_data[p*32 +: 32], exp_rd(p));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] port(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  int n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clear = 0; rd_addr = '0; rd_zero = '0; const_sel = 0;
    constant = '0; wr_en = '0; wr_addr0 = '0; wr_addr1 = '0;
    wr_data0 = '0; wr_data1 = '0;
    cycle(); cycle();
    #2 chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_drop", {31'b0, wr_drop}, 32'd0);
    rst = 0;
    n = 0;
    while (busy && n < 40) begin n++; cycle(); end
    chk("reset_sweep_len", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(a), 4'(a), 4'(a), 4'(a)};
      #1 chk($sformatf("reset_r%0d", a), port(0), 32'h0);
    end
    cycle();

    // write with same-cycle bypass
    wr_en = 2'b01; wr_addr0 = 4'd5; wr_data0 = 32'hDEADBEEF;
    rd_addr = {4'd0, 4'd5, 4'd0, 4'd0};
    #2 chk("bypass_same_cycle", port(2), 32'hDEADBEEF);
    cycle(); wr_en = 2'b00;
    #2 chk("bypass_next_cycle", port(2), 32'hDEADBEEF);
    cycle();

    // dual-write conflict
    wr_en = 2'b11; wr_addr0 = 4'd3; wr_addr1 = 4'd3;
    wr_data0 = 32'h11; wr_data1 = 32'h22;
    cycle(); wr_en = 2'b00; rd_addr = {4'd0, 4'd0, 4'd0, 4'd3};
    #2 chk("conflict_value", port(0), 32'h22);
    chk("conflict_flag", {31'b0, wr_conflict}, 32'd1);
    cycle();
    #2 chk("conflict_pulse_end", {31'b0, wr_conflict}, 32'd0);

    // forwarding priority: port 1 beats port 0 on the same address
    wr_en = 2'b11; wr_addr0 = 4'd9; wr_addr1 = 4'd9;
    wr_data0 = 32'hAAAA; wr_data1 = 32'hBBBB;
    rd_addr = {4'd9, 4'd0, 4'd0, 4'd0};
    #2 chk("bypass_port1_wins", port(3), 32'hBBBB);
    cycle(); wr_en = 2'b00;

    // read priorities
    rd_addr = {4'd0, 4'd0, 4'd5, 4'd3};
    rd_zero = 4'b0001; const_sel = 1; constant = 32'h1234;
    #2 chk("prio_zero_over_const", port(0), 32'h0);
    rd_zero = 4'b0000;
    #1 chk("prio_const", port(0), 32'h1234);
    chk("const_only_port0", port(1), 32'hDEADBEEF);
    rd_zero = 4'b0010;
    #1 chk("rd_zero_port1", port(1), 32'h0);
    cycle(); rd_zero = '0; const_sel = 0;

    // clear sweep with dropped writes, clear re-request ignored
    wr_en = 2'b01; wr_addr0 = 4'd7; wr_data0 = 32'h77;
    clear = 1;
    cycle(); wr_en = 2'b00; clear = 0;
    #2 chk("clear_busy", {31'b0, busy}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      if (n == 3) begin
        wr_en = 2'b11; wr_addr0 = 4'd7; wr_data0 = 32'h55;
        wr_addr1 = 4'd1; wr_data1 = 32'h66;
      end else wr_en = 2'b00;
      clear = (n == 5);
      n++;
      cycle();
      if (n == 4) #2 chk("clear_drop", {31'b0, wr_drop}, 32'd1);
    end
    wr_en = 2'b00; clear = 0;
    chk("clear_sweep_len", n, 32'd16);
    rd_addr = {4'd0, 4'd0, 4'd1, 4'd7};
    #2 chk("clear_r7", port(0), 32'h0);
    chk("clear_r1", port(1), 32'h0);
    cycle();

    // reset mid-sweep restarts the sweep; write under reset is silent
    wr_en = 2'b01; wr_addr0 = 4'd4; wr_data0 = 32'h44;
    cycle(); wr_en = 2'b00;
    clear = 1;
    cycle(); clear = 0;
    for (int k = 0; k < 9; k++) cycle();
    rst = 1; wr_en = 2'b01; wr_addr0 = 4'd2; wr_data0 = 32'h99;
    cycle(); wr_en = 2'b00;
    #2 chk("rst_no_drop", {31'b0, wr_drop}, 32'd0);
    cycle();
    #2 chk("rst_busy_held", {31'b0, busy}, 32'd1);
    rst = 0;
    n = 0;
    while (busy && n < 40) begin n++; cycle(); end
    chk("rst_mid_sweep_len", n, 32'd16);
    rd_addr = {4'd0, 4'd0, 4'd2, 4'd4};
    #2 chk("rst_r4", port(0), 32'h0);
    chk("rst_r2", port(1), 32'h0);
    cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
